// File: rtl/lsu_pkg.sv
// Purpose : shared definitions for the memory-stage load/store unit.
//           RV32I funct3 size/sign codes, FSM state type, and helpers for
//           byte enables, store lane replication and alignment checks.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

  // Reserved funct3 codes fall through to word size.
  function automatic lsu_size_e size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      SZ_B:    byte_en = 4'b0001 << a;
      SZ_H:    byte_en = 4'b0011 << {a[1], 1'b0};
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    case (size_of(f3))
      SZ_B:    store_lanes = {4{d[7:0]}};
      SZ_H:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (size_of(f3))
      SZ_H:    misaligned = a[0];
      SZ_W:    misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Purpose : combinational load lane selection and extension.
// Ports   : rdata_i  raw 32-bit read word
//           addr_i   low address bits selecting the lane
//           funct3_i RV32I size/sign code (reserved codes pass the word)
//           data_o   sign/zero-extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[{addr_i, 3'b000} +: 8];
    h = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{24{b[7]}}, b};
      F3_BU:   data_o = {24'h0, b};
      F3_H:    data_o = {{16{h[15]}}, h};
      F3_HU:   data_o = {16'h0, h};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/stage_mem_lsu.sv
// Purpose : memory-stage load/store unit. Takes the EX effective address and
//           store data, runs one req/gnt/rvalid bus transaction per request
//           and returns extended load data with a one-cycle resp_valid pulse.
// Ports   : req_*  request from EX (valid/ready handshake)
//           stall  pipeline hold while a transaction is in flight
//           resp_* completion pulse, load data, error flag
//           mem_*  data-memory bus
// Config  : define LSU_MISALIGN_TRAP_EN to abort misaligned H/W accesses
//           without a bus cycle (resp_err=1); otherwise low bits are ignored.
module stage_mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          stall,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  // Abort fires in the MAX_WAIT-th cycle spent waiting in a state.
  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  lsu_state_e    state_q, state_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   ld_data;
  logic          trap;
  logic          timeout;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_load_align u_align (
    .rdata_i  (mem_rdata),
    .addr_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (ld_data)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    timeout = (cnt_q == WAIT_LAST);
    case (state_q)
      S_IDLE: if (req_valid) begin
        err_d   = 1'b0;
        rdata_d = '0;
        if (trap) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // Grant wins over timeout; grant with rvalid skips WAIT.
        if (mem_gnt) begin
          if (mem_rvalid) begin
            state_d = S_RESP;
            rdata_d = we_q ? '0 : ld_data;
          end else begin
            state_d = S_WAIT;
          end
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_RESP;
          rdata_d = we_q ? '0 : ld_data;
        end else if (timeout) begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q)                          cnt_d = '0;
    else if (state_q == S_REQ || state_q == S_WAIT)  cnt_d = cnt_q + 4'd1;
    else                                             cnt_d = cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    req_ready  = (state_q == S_IDLE);
    stall      = (state_q == S_REQ) || (state_q == S_WAIT);
    resp_valid = (state_q == S_RESP);
    resp_rdata = (state_q == S_RESP) ? rdata_q : '0;
    resp_err   = (state_q == S_RESP) && err_q;
    mem_req    = (state_q == S_REQ);
    mem_we     = (state_q == S_REQ) && we_q;
    mem_addr   = (state_q == S_REQ) ? {addr_q[AW-1:2], 2'b00} : '0;
    mem_be     = (state_q == S_REQ) ? byte_en(f3_q, addr_q[1:0]) : '0;
    mem_wdata  = (state_q == S_REQ) ? store_lanes(f3_q, wdata_q) : '0;
  end

endmodule

// File: tb/tb_stage_mem_lsu.sv
module tb_stage_mem_lsu;

  localparam int MAXW = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        stall, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  stage_mem_lsu #(.AW(32), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  typedef struct { logic [31:0] rdata; logic err; int req_cycles; int stall_cycles; } resp_t;
  typedef struct { logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata; } bus_t;

  resp_t rq[$];
  bus_t  bq[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    if (n == 4) return 0;
    if (n == 2) return ((a % 4) / 2) * 2;
    return a % 4;
  endfunction

  function automatic bit model_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    int n = nbytes(f3);
    return (n == 2 && (a % 2) != 0) || (n == 4 && (a % 4) != 0);
`else
    return (f3 === 3'bxxx);
`endif
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(f3);
    int v = ((1 << n) - 1) << lane_off(f3, a);
    return v[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int n = nbytes(f3);
    for (int k = 0; k < 4; k++) w[8*k +: 8] = d[8*(k % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    int n = nbytes(f3);
    longint unsigned v, mask;
    v = longint'(rd) >> (8 * lane_off(f3, a));
    if (n < 4) begin
      mask = (64'd1 << (8 * n)) - 1;
      v = v & mask;
      if ((f3 == 3'd0 || f3 == 3'd1) && v[8*n-1]) v = v | (64'hFFFF_FFFF & ~mask);
    end
    return v[31:0];
  endfunction

  // ---------------- monitor ----------------
  int reqc = 0, stallc = 0;
  always @(negedge clk) begin
    bus_t  b;
    resp_t r;
    if (!rst_n) begin
      reqc = 0;
      stallc = 0;
    end else begin
      if (mem_req) reqc++;
      if (stall) stallc++;
      if (mem_req && mem_gnt) begin
        if (bq.size() == 0) check("unexpected_bus_cycle", {31'd0, mem_gnt}, 32'd0);
        else begin
          b = bq.pop_front();
          check("mem_addr", mem_addr, b.addr);
          check("mem_be", {28'd0, mem_be}, {28'd0, b.be});
          check("mem_we", {31'd0, mem_we}, {31'd0, b.we});
          if (b.we) check("mem_wdata", mem_wdata, b.wdata);
        end
      end
      if (resp_valid) begin
        if (rq.size() == 0) check("unexpected_resp", {31'd0, resp_valid}, 32'd0);
        else begin
          r = rq.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, r.err});
          check("req_cycles", reqc, r.req_cycles);
          check("stall_cycles", stallc, r.stall_cycles);
          check("stall_in_resp", {31'd0, stall}, 32'd0);
        end
        reqc = 0;
        stallc = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready;
    int k = 0;
    while (!req_ready && k < 100) begin
      step();
      k++;
    end
    if (!req_ready) check("ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  // g: REQ cycles before grant; r<0: rvalid together with grant, else WAIT
  // cycles before rvalid. no_gnt/no_rv suppress grant/rvalid to force timeout.
  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd,
                       input int g, input int r, input bit no_gnt, input bit no_rv);
    resp_t e;
    bus_t  b;
    bit    trap;
    wait_ready();
    trap = model_trap(f3, a);
    b.addr = a & 32'hFFFF_FFFC;
    b.be = model_be(f3, a);
    b.we = we;
    b.wdata = model_wdata(f3, d);
    if (!trap && !no_gnt) bq.push_back(b);
    e.rdata = '0;
    e.err = 1'b1;
    if (trap) begin
      e.req_cycles = 0;
      e.stall_cycles = 0;
    end else if (no_gnt) begin
      e.req_cycles = MAXW;
      e.stall_cycles = MAXW;
    end else if (no_rv) begin
      e.req_cycles = g + 1;
      e.stall_cycles = g + 1 + MAXW;
    end else begin
      e.err = 1'b0;
      e.rdata = we ? 32'd0 : model_load(f3, a, rd);
      e.req_cycles = g + 1;
      e.stall_cycles = g + 1 + ((r < 0) ? 0 : r + 1);
    end
    rq.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    if (!trap && !no_gnt) begin
      repeat (g) step();
      mem_gnt = 1'b1;
      mem_rvalid = (r < 0) && !no_rv;
      mem_rdata = rd;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (r >= 0 && !no_rv) begin
        repeat (r) step();
        mem_rvalid = 1'b1;
        mem_rdata = rd;
        step();
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_t b;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    step();

    do_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_55CC, 0, -1, 0, 0); // LB
    do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 0, 0, 0, 0);  // LHU
    do_op(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, 3, 1, 0, 0);  // LW late gnt
    do_op(1'b1, 3'b000, 32'h0000_0010, 32'h1234_5678, 32'h0, 0, 0, 0, 0);  // SB
    do_op(1'b1, 3'b001, 32'h0000_0012, 32'h1234_5678, 32'h0, 1, -1, 0, 0); // SH
    do_op(1'b0, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 0, 0, 1, 0);          // gnt timeout
    wait_ready();
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_rvalid = 1'b0;
    step();
    check("stray_ready", {31'd0, req_ready}, 32'd1);
    check("stray_stall", {31'd0, stall}, 32'd0);
    do_op(1'b0, 3'b001, 32'h0000_5002, 32'h0, 32'h0, 2, 0, 0, 1);          // rvalid timeout
    do_op(1'b0, 3'b010, 32'h0000_0001, 32'h0, 32'hCAFE_F00D, 0, -1, 0, 0); // misaligned LW

    // reset while in WAIT: transaction dropped, no response
    wait_ready();
    b.addr = 32'h0000_6000; b.be = 4'b1111; b.we = 1'b0; b.wdata = '0;
    bq.push_back(b);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_6000;
    step();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    step();
    check("wait_stall", {31'd0, stall}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 60; i++) begin
      logic        we;
      logic [2:0]  f3;
      we = 1'($urandom);
      f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom);
      do_op(we, f3, $urandom, $urandom, $urandom,
            int'($urandom_range(0, 4)), int'($urandom_range(0, 4)) - 1, 0, 0);
    end

    wait_ready();
    repeat (3) step();
    check("resp_queue_drained", rq.size(), 32'd0);
    check("bus_queue_drained", bq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
